score_keeper: RTL and testbench



---
 rtl/score_keeper.sv | 135 +++++++++++++
 tb/tb_score_keeper.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Score keeper: responds to sticky collision requests with sticky acks, keeps
// score and lives, and sequences the PLAY / FLASH / OVER game states.
module score_keeper #(
  parameter int unsigned COIN_PTS     = 5,
  parameter int unsigned STOMP_PTS    = 10,
  parameter int unsigned HIT_PENALTY  = 2,
  parameter int unsigned MAX_SCORE    = 999,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned FLASH_FRAMES = 60
) (
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       coin1_d,
  input  logic       coin2_d,
  input  logic       coin3_d,
  input  logic       goomba1_d1,
  input  logic       goomba1_d2,
  output logic       score_addedc1,
  output logic       score_addedc2,
  output logic       score_addedc3,
  output logic       score_addedg1,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic       award_pulse,
  output logic       hit_flash,
  output logic       game_over
);

  localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [10:0] COIN11  = 11'(COIN_PTS);
  localparam logic [10:0] STOMP11 = 11'(STOMP_PTS);
  localparam logic [10:0] PEN11   = 11'(HIT_PENALTY);
  localparam logic [10:0] MAX11   = 11'(MAX_SCORE);

  typedef enum logic [1:0] {PLAY, FLASH, OVER} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] flash_cnt, flash_cnt_nxt;
  logic [9:0]       score_nxt;
  logic [1:0]       lives_nxt;
  logic [3:0]       acks_nxt;
  logic             pulse_nxt;
  logic [4:0]       pending;
  logic [10:0]      coin_sum, stomp_sum, coin_sat, stomp_sat, hit_res;

  // stomp and hit share the goomba 1 ack, so the first one serviced locks out the other
  assign pending = {coin1_d    & ~score_addedc1,
                    coin2_d    & ~score_addedc2,
                    coin3_d    & ~score_addedc3,
                    goomba1_d1 & ~score_addedg1,
                    goomba1_d2 & ~score_addedg1};

  assign coin_sum  = {1'b0, score} + COIN11;
  assign stomp_sum = {1'b0, score} + STOMP11;
  assign coin_sat  = (coin_sum  > MAX11) ? MAX11 : coin_sum;
  assign stomp_sat = (stomp_sum > MAX11) ? MAX11 : stomp_sum;
  assign hit_res   = ({1'b0, score} >= PEN11) ? ({1'b0, score} - PEN11) : '0;

  assign hit_flash = (state == FLASH);
  assign game_over = (state == OVER);

  always_comb begin
    state_nxt     = state;
    flash_cnt_nxt = flash_cnt;
    score_nxt     = score;
    lives_nxt     = lives;
    acks_nxt      = {score_addedc1, score_addedc2, score_addedc3, score_addedg1};
    pulse_nxt     = 1'b0;

    if (state == FLASH) begin
      if (flash_cnt == '0) state_nxt = PLAY;
      else                 flash_cnt_nxt = flash_cnt - CNT_W'(1);
    end

    if (state != OVER) begin
      if (pending[4]) begin
        acks_nxt[3] = 1'b1;
        score_nxt   = coin_sat[9:0];
        pulse_nxt   = 1'b1;
      end else if (pending[3]) begin
        acks_nxt[2] = 1'b1;
        score_nxt   = coin_sat[9:0];
        pulse_nxt   = 1'b1;
      end else if (pending[2]) begin
        acks_nxt[1] = 1'b1;
        score_nxt   = coin_sat[9:0];
        pulse_nxt   = 1'b1;
      end else if (pending[1]) begin
        acks_nxt[0] = 1'b1;
        score_nxt   = stomp_sat[9:0];
        pulse_nxt   = 1'b1;
      end else if (pending[0]) begin
        acks_nxt[0] = 1'b1;
        score_nxt   = hit_res[9:0];
        pulse_nxt   = 1'b1;
        // a hit during FLASH costs points only; lives and the window are untouched
        if (state == PLAY) begin
          if (lives <= 2'd1) begin
            lives_nxt = '0;
            state_nxt = OVER;
          end else begin
            lives_nxt     = lives - 2'd1;
            state_nxt     = FLASH;
            flash_cnt_nxt = CNT_W'(FLASH_FRAMES - 1);
          end
        end
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state         <= PLAY;
      flash_cnt     <= '0;
      score         <= '0;
      lives         <= 2'(START_LIVES);
      award_pulse   <= 1'b0;
      score_addedc1 <= 1'b0;
      score_addedc2 <= 1'b0;
      score_addedc3 <= 1'b0;
      score_addedg1 <= 1'b0;
    end else begin
      state         <= state_nxt;
      flash_cnt     <= flash_cnt_nxt;
      score         <= score_nxt;
      lives         <= lives_nxt;
      award_pulse   <= pulse_nxt;
      score_addedc1 <= acks_nxt[3];
      score_addedc2 <= acks_nxt[2];
      score_addedc3 <= acks_nxt[1];
      score_addedg1 <= acks_nxt[0];
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: default-parameter vector table plus
// saturation, short-flash and game-over corner sequences on extra instances.
module tb_score_keeper;

  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // req ordering: {coin1, coin2, coin3, goomba1_d1, goomba1_d2}
  logic       m_rst, s_rst, g_rst;
  logic [4:0] m_req, s_req, g_req;
  logic       m_c1, m_c2, m_c3, m_g1, s_c1, s_c2, s_c3, s_g1, g_c1, g_c2, g_c3, g_g1;
  logic [9:0] m_score, s_score, g_score;
  logic [1:0] m_lives, s_lives, g_lives;
  logic       m_pulse, s_pulse, g_pulse, m_flash, s_flash, g_flash, m_over, s_over, g_over;
  logic [18:0] m_obs, s_obs, g_obs;

  score_keeper u_main (
    .frame_clk(frame_clk), .reset(m_rst),
    .coin1_d(m_req[4]), .coin2_d(m_req[3]), .coin3_d(m_req[2]),
    .goomba1_d1(m_req[1]), .goomba1_d2(m_req[0]),
    .score_addedc1(m_c1), .score_addedc2(m_c2), .score_addedc3(m_c3), .score_addedg1(m_g1),
    .score(m_score), .lives(m_lives), .award_pulse(m_pulse),
    .hit_flash(m_flash), .game_over(m_over));

  score_keeper #(.MAX_SCORE(12), .FLASH_FRAMES(3)) u_sat (
    .frame_clk(frame_clk), .reset(s_rst),
    .coin1_d(s_req[4]), .coin2_d(s_req[3]), .coin3_d(s_req[2]),
    .goomba1_d1(s_req[1]), .goomba1_d2(s_req[0]),
    .score_addedc1(s_c1), .score_addedc2(s_c2), .score_addedc3(s_c3), .score_addedg1(s_g1),
    .score(s_score), .lives(s_lives), .award_pulse(s_pulse),
    .hit_flash(s_flash), .game_over(s_over));

  score_keeper #(.START_LIVES(1)) u_go (
    .frame_clk(frame_clk), .reset(g_rst),
    .coin1_d(g_req[4]), .coin2_d(g_req[3]), .coin3_d(g_req[2]),
    .goomba1_d1(g_req[1]), .goomba1_d2(g_req[0]),
    .score_addedc1(g_c1), .score_addedc2(g_c2), .score_addedc3(g_c3), .score_addedg1(g_g1),
    .score(g_score), .lives(g_lives), .award_pulse(g_pulse),
    .hit_flash(g_flash), .game_over(g_over));

  assign m_obs = {m_score, m_c1, m_c2, m_c3, m_g1, m_lives, m_pulse, m_flash, m_over};
  assign s_obs = {s_score, s_c1, s_c2, s_c3, s_g1, s_lives, s_pulse, s_flash, s_over};
  assign g_obs = {g_score, g_c1, g_c2, g_c3, g_g1, g_lives, g_pulse, g_flash, g_over};

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [18:0] exp;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t vecs[22];

  function automatic logic [18:0] ex(input int unsigned sc, input logic [3:0] acks,
                                     input int unsigned lv, input logic p, input logic f,
                                     input logic o);
    return {10'(sc), acks, 2'(lv), p, f, o};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [4:0] req, input logic [18:0] e);
    vec_t v;
    v.rst = rst; v.req = req; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  int unsigned cnt;

  initial begin
    m_rst = 1'b1; s_rst = 1'b1; g_rst = 1'b1;
    m_req = '0;   s_req = '0;   g_req = '0;

    vecs[0]  = mk(1, 5'b00000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[1]  = mk(0, 5'b10000, ex(5,  4'b1000, 3, 1, 0, 0));
    vecs[2]  = mk(0, 5'b10000, ex(5,  4'b1000, 3, 0, 0, 0));
    vecs[3]  = mk(0, 5'b10000, ex(5,  4'b1000, 3, 0, 0, 0));
    vecs[4]  = mk(1, 5'b10000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[5]  = mk(0, 5'b10000, ex(5,  4'b1000, 3, 1, 0, 0));
    vecs[6]  = mk(1, 5'b00000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[7]  = mk(0, 5'b11110, ex(5,  4'b1000, 3, 1, 0, 0));
    vecs[8]  = mk(0, 5'b11110, ex(10, 4'b1100, 3, 1, 0, 0));
    vecs[9]  = mk(0, 5'b11110, ex(15, 4'b1110, 3, 1, 0, 0));
    vecs[10] = mk(0, 5'b11110, ex(25, 4'b1111, 3, 1, 0, 0));
    vecs[11] = mk(0, 5'b11110, ex(25, 4'b1111, 3, 0, 0, 0));
    vecs[12] = mk(1, 5'b00000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[13] = mk(0, 5'b01000, ex(5,  4'b0100, 3, 1, 0, 0));
    vecs[14] = mk(0, 5'b00011, ex(15, 4'b0101, 3, 1, 0, 0));
    vecs[15] = mk(0, 5'b00001, ex(15, 4'b0101, 3, 0, 0, 0));
    vecs[16] = mk(1, 5'b00000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[17] = mk(0, 5'b00001, ex(0,  4'b0001, 2, 1, 1, 0));
    vecs[18] = mk(0, 5'b00000, ex(0,  4'b0001, 2, 0, 1, 0));
    vecs[19] = mk(1, 5'b00000, ex(0,  4'b0000, 3, 0, 0, 0));
    vecs[20] = mk(0, 5'b10000, ex(5,  4'b1000, 3, 1, 0, 0));
    vecs[21] = mk(0, 5'b00001, ex(3,  4'b1001, 2, 1, 1, 0));

    for (int i = 0; i < 22; i++) begin
      m_rst = vecs[i].rst;
      m_req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), 32'(m_obs), 32'(vecs[i].exp));
    end

    // flash window length: vec21 already showed the first flash cycle
    m_req = '0;
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!m_flash) break;
      cnt++;
    end
    check("flash_len", cnt, 60);

    m_req = 5'b00010;
    tick();
    check("stomp_after_hit", 32'(m_obs), 32'(ex(3, 4'b1001, 2, 0, 0, 0)));

    // reset on the 20th flash cycle
    m_req = '0; m_rst = 1'b1; tick();
    m_rst = 1'b0; m_req = 5'b00100; tick();
    m_req = 5'b00101; tick();
    check("midflash_hit", 32'(m_obs), 32'(ex(3, 4'b0011, 2, 1, 1, 0)));
    m_req = 5'b00101;
    for (int i = 0; i < 19; i++) tick();
    check("midflash_still_on", 32'(m_flash), 1);
    m_rst = 1'b1; tick();
    check("midflash_reset", 32'(m_obs), 32'(ex(0, 4'b0000, 3, 0, 0, 0)));
    m_rst = 1'b0; m_req = '0;

    // saturation at MAX_SCORE=12 and a 3-frame flash window
    s_rst = 1'b1; tick();
    s_rst = 1'b0; s_req = 5'b11100; tick();
    check("sat_c1", 32'(s_obs), 32'(ex(5,  4'b1000, 3, 1, 0, 0)));
    tick();
    check("sat_c2", 32'(s_obs), 32'(ex(10, 4'b1100, 3, 1, 0, 0)));
    tick();
    check("sat_c3", 32'(s_obs), 32'(ex(12, 4'b1110, 3, 1, 0, 0)));
    s_req = 5'b11101; tick();
    check("sat_hit", 32'(s_obs), 32'(ex(10, 4'b1111, 2, 1, 1, 0)));
    s_req = '0;
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!s_flash) break;
      cnt++;
    end
    check("short_flash_len", cnt, 3);

    // game over with a single life
    g_rst = 1'b1; tick();
    check("go_reset", 32'(g_obs), 32'(ex(0, 4'b0000, 1, 0, 0, 0)));
    g_rst = 1'b0; g_req = 5'b10000; tick();
    check("go_coin", 32'(g_obs), 32'(ex(5, 4'b1000, 1, 1, 0, 0)));
    g_req = 5'b10001; tick();
    check("go_hit", 32'(g_obs), 32'(ex(3, 4'b1001, 0, 1, 0, 1)));
    g_req = 5'b01000; tick();
    check("go_frozen", 32'(g_obs), 32'(ex(3, 4'b1001, 0, 0, 0, 1)));
    tick();
    check("go_frozen2", 32'(g_obs), 32'(ex(3, 4'b1001, 0, 0, 0, 1)));
    g_rst = 1'b1; g_req = '0; tick();
    check("go_rst", 32'(g_obs), 32'(ex(0, 4'b0000, 1, 0, 0, 0)));
    g_rst = 1'b0; g_req = 5'b01000; tick();
    check("go_replay", 32'(g_obs), 32'(ex(5, 4'b0100, 1, 1, 0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
